// File: rtl/ifm_pkg.sv
// ifm_pkg: shared definitions for the mm2s TX framing engine.
//   - FSM state encodings (also exported on the debug port)
//   - control-stream constants (frame flag, control block length)
//   - bit positions of the last/keep/EOF fields in the FIFO words
//   - info-word field offsets, shared with the MAC-side info reader
package ifm_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CTRL = 3'd1,
      S_DATA = 3'd2,
      S_DROP = 3'd3,
      S_INFO = 3'd4
   } ifm_state_e;

   // Control block framing
   localparam int          C_CTRL_WORDS = 6;
   localparam logic [3:0]  C_TX_FLAG    = 4'hA;
   localparam logic [2:0]  C_LAST_IDX   = 3'(C_CTRL_WORDS - 1);
   localparam logic [2:0]  C_WIDX_OVF   = 3'(C_CTRL_WORDS);

   // Control FIFO word: [36]=last, [35:32]=keep, [31:0]=word
   localparam int CTRL_LAST_BIT  = 36;
   localparam int CTRL_KEEP_MSB  = 35;
   localparam int CTRL_KEEP_LSB  = 32;
   localparam int CTRL_FLAG_MSB  = 31;
   localparam int CTRL_FLAG_LSB  = 28;
   localparam int CTRL_CSUM_BIT  = 0;

   // Data FIFO word: [72]=EOF, [71:64]=byte enables, [63:0]=data
   localparam int DATA_EOF_BIT   = 72;
   localparam int DATA_KEEP_MSB  = 71;
   localparam int DATA_KEEP_LSB  = 64;

   // Info word: [15:0]=byte count, [16]=csum_en, [31:17]=0
   localparam int INFO_BCNT_LSB  = 0;
   localparam int INFO_BCNT_W    = 16;
   localparam int INFO_CSUM_BIT  = 16;

   function automatic logic [31:0] info_pack(input logic [15:0] bcnt, input logic csum);
      logic [31:0] w;
      w = '0;
      w[INFO_BCNT_LSB +: INFO_BCNT_W] = bcnt;
      w[INFO_CSUM_BIT] = csum;
      return w;
   endfunction

endpackage

// File: rtl/ifm_keep_cnt.sv
// ifm_keep_cnt: byte-enable to byte-count converter.
// Only contiguous low-aligned enables (8'h01..8'hFF) are legal beat
// shapes; anything else counts as zero bytes.
//   keep  in  8  byte enables of one 64-bit beat
//   cnt   out 4  number of valid bytes (0..8)
module ifm_keep_cnt (
   input  logic [7:0] keep,
   output logic [3:0] cnt
);

   always_comb begin
      cnt = 4'd0;
      case (keep)
         8'h01:   cnt = 4'd1;
         8'h03:   cnt = 4'd2;
         8'h07:   cnt = 4'd3;
         8'h0F:   cnt = 4'd4;
         8'h1F:   cnt = 4'd5;
         8'h3F:   cnt = 4'd6;
         8'h7F:   cnt = 4'd7;
         8'hFF:   cnt = 4'd8;
         default: cnt = 4'd0;
      endcase
   end

endmodule

// File: rtl/ifm_in_fsm.sv
// ifm_in_fsm: mm2s TX framing engine.
// Reads a control block and the matching data beats from the mm2s FIFOs,
// forwards the data to the MAC-side TX data FIFO and closes each frame
// with one info word. Frames with a malformed control block are drained
// from the data FIFO without any TX writes and counted in drop_cnt.
//
// Ports:
//   mm2s_clk, mm2s_reset         clock, synchronous active-high reset
//   ctrl_fifo_rdata/empty/rden   FWFT control stream (rden combinational)
//   data_fifo_rdata/empty/rden   FWFT data stream (rden combinational)
//   tx_fifo_wdata/wren/afull     MAC-side TX data FIFO write port
//   tx_info_wdata/wren/afull     MAC-side TX info FIFO write port
//   drop_cnt                     saturating count of dropped frames
//   ifm_in_fsm_dbg               {tx_fifo_afull, state}
//
// state  | meaning
// -------+-------------------------------------------------------
// S_IDLE | wait for a control block and room in both TX FIFOs
// S_CTRL | pop and decode control words up to the last flag
// S_DATA | forward data beats, accumulate byte count until EOF
// S_DROP | discard data beats of a bad frame until EOF
// S_INFO | emit the per-frame info word
module ifm_in_fsm
   import ifm_pkg::*;
(
   input  logic        mm2s_clk,
   input  logic        mm2s_reset,
   input  logic [36:0] ctrl_fifo_rdata,
   input  logic        ctrl_fifo_empty,
   output logic        ctrl_fifo_rden,
   input  logic [72:0] data_fifo_rdata,
   input  logic        data_fifo_empty,
   output logic        data_fifo_rden,
   output logic [72:0] tx_fifo_wdata,
   output logic        tx_fifo_wren,
   input  logic        tx_fifo_afull,
   output logic [31:0] tx_info_wdata,
   output logic        tx_info_wren,
   input  logic        tx_info_afull,
   output logic [15:0] drop_cnt,
   output logic [3:0]  ifm_in_fsm_dbg
);

   ifm_state_e  state_q, state_d;
   logic [2:0]  widx_q, widx_d;
   logic [15:0] bytecnt_q, bytecnt_d;
   logic        csum_en_q, csum_en_d;
   logic        bad_q, bad_d;
   logic [72:0] tx_fifo_wdata_q, tx_fifo_wdata_d;
   logic        tx_fifo_wren_q, tx_fifo_wren_d;
   logic [31:0] tx_info_wdata_q, tx_info_wdata_d;
   logic        tx_info_wren_q, tx_info_wren_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   logic        ctrl_pop;
   logic        data_pop;
   logic        bad_v;
   logic [16:0] bytecnt_sum;
   logic [3:0]  keep_cnt;

   logic        ctrl_last;
   logic        data_eof;
   logic [3:0]  ctrl_flag;

   // Control fields that the engine does not interpret.
   logic        unused_ctrl_bits;
   assign unused_ctrl_bits = ^{ctrl_fifo_rdata[CTRL_KEEP_MSB:CTRL_KEEP_LSB],
                               ctrl_fifo_rdata[CTRL_FLAG_LSB-1:CTRL_CSUM_BIT+1]};

   assign ctrl_last = ctrl_fifo_rdata[CTRL_LAST_BIT];
   assign ctrl_flag = ctrl_fifo_rdata[CTRL_FLAG_MSB:CTRL_FLAG_LSB];
   assign data_eof  = data_fifo_rdata[DATA_EOF_BIT];

   ifm_keep_cnt u_keep_cnt (
      .keep (data_fifo_rdata[DATA_KEEP_MSB:DATA_KEEP_LSB]),
      .cnt  (keep_cnt)
   );

   always_comb begin
      state_d         = state_q;
      widx_d          = widx_q;
      bytecnt_d       = bytecnt_q;
      csum_en_d       = csum_en_q;
      bad_d           = bad_q;
      tx_fifo_wdata_d = tx_fifo_wdata_q;
      tx_fifo_wren_d  = 1'b0;
      tx_info_wdata_d = tx_info_wdata_q;
      tx_info_wren_d  = 1'b0;
      drop_cnt_d      = drop_cnt_q;
      ctrl_pop        = 1'b0;
      data_pop        = 1'b0;
      bad_v           = bad_q;
      bytecnt_sum     = {1'b0, bytecnt_q} + {13'd0, keep_cnt};

      case (state_q)
         S_IDLE: begin
            widx_d    = 3'd0;
            bytecnt_d = 16'd0;
            csum_en_d = 1'b0;
            bad_d     = 1'b0;
            if (!ctrl_fifo_empty && !tx_info_afull && !tx_fifo_afull)
               state_d = S_CTRL;
         end

         S_CTRL: begin
            ctrl_pop = !ctrl_fifo_empty;
            if (ctrl_pop) begin
               if (widx_q == 3'd0 && ctrl_flag != C_TX_FLAG)
                  bad_v = 1'b1;
               if (widx_q == 3'd1)
                  csum_en_d = ctrl_fifo_rdata[CTRL_CSUM_BIT];
               if (ctrl_last) begin
                  // The drop decision must see this word's own update.
                  if (widx_q != C_LAST_IDX)
                     bad_v = 1'b1;
                  state_d = bad_v ? S_DROP : S_DATA;
               end else if (widx_q >= C_WIDX_OVF) begin
                  bad_v = 1'b1;
               end
               bad_d = bad_v;
               if (widx_q != 3'd7)
                  widx_d = widx_q + 3'd1;
            end
         end

         S_DATA: begin
            data_pop = !data_fifo_empty && !tx_fifo_afull;
            if (data_pop) begin
               tx_fifo_wdata_d = data_fifo_rdata;
               tx_fifo_wren_d  = 1'b1;
               bytecnt_d       = bytecnt_sum[16] ? 16'hFFFF : bytecnt_sum[15:0];
               if (data_eof)
                  state_d = S_INFO;
            end
         end

         S_DROP: begin
            data_pop = !data_fifo_empty;
            if (data_pop && data_eof) begin
               if (drop_cnt_q != 16'hFFFF)
                  drop_cnt_d = drop_cnt_q + 16'd1;
               state_d = S_IDLE;
            end
         end

         S_INFO: begin
            // The final data write is already in flight, so the info
            // write lands strictly after it.
            tx_info_wren_d  = 1'b1;
            tx_info_wdata_d = info_pack(bytecnt_q, csum_en_q);
            state_d         = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge mm2s_clk) begin
      if (mm2s_reset) begin
         state_q         <= S_IDLE;
         widx_q          <= 3'd0;
         bytecnt_q       <= 16'd0;
         csum_en_q       <= 1'b0;
         bad_q           <= 1'b0;
         tx_fifo_wdata_q <= '0;
         tx_fifo_wren_q  <= 1'b0;
         tx_info_wdata_q <= '0;
         tx_info_wren_q  <= 1'b0;
         drop_cnt_q      <= 16'd0;
      end else begin
         state_q         <= state_d;
         widx_q          <= widx_d;
         bytecnt_q       <= bytecnt_d;
         csum_en_q       <= csum_en_d;
         bad_q           <= bad_d;
         tx_fifo_wdata_q <= tx_fifo_wdata_d;
         tx_fifo_wren_q  <= tx_fifo_wren_d;
         tx_info_wdata_q <= tx_info_wdata_d;
         tx_info_wren_q  <= tx_info_wren_d;
         drop_cnt_q      <= drop_cnt_d;
      end
   end

   assign ctrl_fifo_rden = ctrl_pop;
   assign data_fifo_rden = data_pop;
   assign tx_fifo_wdata  = tx_fifo_wdata_q;
   assign tx_fifo_wren   = tx_fifo_wren_q;
   assign tx_info_wdata  = tx_info_wdata_q;
   assign tx_info_wren   = tx_info_wren_q;
   assign drop_cnt       = drop_cnt_q;
   assign ifm_in_fsm_dbg = {tx_fifo_afull, state_q};

endmodule

// File: tb/tb_ifm_in_fsm.sv
module tb_ifm_in_fsm;
   import ifm_pkg::*;

   logic        mm2s_clk = 1'b0;
   logic        mm2s_reset;
   logic [36:0] ctrl_fifo_rdata;
   logic        ctrl_fifo_empty;
   logic        ctrl_fifo_rden;
   logic [72:0] data_fifo_rdata;
   logic        data_fifo_empty;
   logic        data_fifo_rden;
   logic [72:0] tx_fifo_wdata;
   logic        tx_fifo_wren;
   logic        tx_fifo_afull;
   logic [31:0] tx_info_wdata;
   logic        tx_info_wren;
   logic        tx_info_afull;
   logic [15:0] drop_cnt;
   logic [3:0]  ifm_in_fsm_dbg;

   always #5 mm2s_clk = ~mm2s_clk;

   ifm_in_fsm dut (
      .mm2s_clk        (mm2s_clk),
      .mm2s_reset      (mm2s_reset),
      .ctrl_fifo_rdata (ctrl_fifo_rdata),
      .ctrl_fifo_empty (ctrl_fifo_empty),
      .ctrl_fifo_rden  (ctrl_fifo_rden),
      .data_fifo_rdata (data_fifo_rdata),
      .data_fifo_empty (data_fifo_empty),
      .data_fifo_rden  (data_fifo_rden),
      .tx_fifo_wdata   (tx_fifo_wdata),
      .tx_fifo_wren    (tx_fifo_wren),
      .tx_fifo_afull   (tx_fifo_afull),
      .tx_info_wdata   (tx_info_wdata),
      .tx_info_wren    (tx_info_wren),
      .tx_info_afull   (tx_info_afull),
      .drop_cnt        (drop_cnt),
      .ifm_in_fsm_dbg  (ifm_in_fsm_dbg)
   );

   typedef struct {
      string       name;
      logic [31:0] w0;
      logic [31:0] w1;
      int          nctrl;
      int          nbeats;
      logic [7:0]  kbody;
      logic [7:0]  klast;
      bit          ok;
      logic [31:0] info;
   } vec_t;

   vec_t        tbl[7];
   logic [36:0] cq[$];
   logic [72:0] dq[$];
   logic [72:0] exp_q[$];
   int          c_cnt, d_cnt;
   bit          c_force_empty, d_force_empty;
   bit          pc, pd, bp_check;
   int          n_vec, n_err;
   int          tx_wr_cnt, info_cnt;
   logic [31:0] last_info;
   int          exp_drop;
   logic [31:0] seed;

   assign ctrl_fifo_empty = (c_cnt == 0) || c_force_empty;
   assign data_fifo_empty = (d_cnt == 0) || d_force_empty;

   function automatic void refresh();
      c_cnt = cq.size();
      d_cnt = dq.size();
      ctrl_fifo_rdata = '0;
      data_fifo_rdata = '0;
      if (c_cnt != 0) ctrl_fifo_rdata = cq[0];
      if (d_cnt != 0) data_fifo_rdata = dq[0];
   endfunction

   task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic flag_err(input string name, input logic [72:0] act);
      n_vec++;
      n_err++;
      $display("FAIL %s: got %0h, expected no such event", name, act);
   endtask

   task automatic tick();
      @(posedge mm2s_clk);
      #2;
   endtask

   // FIFO models: pops decided from rden sampled mid-cycle, applied after the edge.
   always @(negedge mm2s_clk) begin
      pc = ctrl_fifo_rden;
      pd = data_fifo_rden;
      if (mm2s_reset === 1'b0) begin
         if (ctrl_fifo_rden && data_fifo_rden) flag_err("both_rden", 1);
         if (ctrl_fifo_rden && ctrl_fifo_empty) flag_err("ctrl_rden_empty", 1);
         if (data_fifo_rden && data_fifo_empty) flag_err("data_rden_empty", 1);
         if (bp_check && data_fifo_rden && tx_fifo_afull) flag_err("data_rden_afull", 1);
         if (tx_fifo_wren) begin
            tx_wr_cnt++;
            if (exp_q.size() == 0) flag_err("tx_unexpected", tx_fifo_wdata);
            else chk("tx_beat", tx_fifo_wdata, exp_q.pop_front());
         end
         if (tx_info_wren) begin
            info_cnt++;
            last_info = tx_info_wdata;
            if (tx_fifo_wren) flag_err("info_with_tx", tx_info_wdata);
         end
      end
   end

   always @(posedge mm2s_clk) begin
      #1;
      if (pc && cq.size() != 0) void'(cq.pop_front());
      if (pd && dq.size() != 0) void'(dq.pop_front());
      pc = 1'b0;
      pd = 1'b0;
      refresh();
   end

   task automatic push_frame(input logic [31:0] w0, input logic [31:0] w1, input int nctrl,
                             input int nbeats, input logic [7:0] kbody, input logic [7:0] klast,
                             input bit ok);
      logic [31:0] word;
      logic [72:0] d;
      logic [7:0]  k;
      for (int i = 0; i < nctrl; i++) begin
         word = (i == 0) ? w0 : (i == 1) ? w1 : 32'h0;
         cq.push_back({(i == nctrl - 1), 4'hF, word});
      end
      for (int b = 0; b < nbeats; b++) begin
         k = (b == nbeats - 1) ? klast : kbody;
         d = {(b == nbeats - 1), k, seed, 32'(b)};
         seed = seed + 32'h0101_0101;
         dq.push_back(d);
         if (ok) exp_q.push_back(d);
      end
      refresh();
   endtask

   task automatic wait_done(input string name);
      int k;
      for (k = 0; k < 400; k++) begin
         if (cq.size() == 0 && dq.size() == 0 && ifm_in_fsm_dbg[2:0] == 3'd0) break;
         tick();
      end
      if (k == 400) flag_err({name, "_timeout"}, ifm_in_fsm_dbg);
      repeat (3) tick();
   endtask

   task automatic check_frame(input string name, input int beats, input bit ok, input logic [31:0] info);
      chk({name, "_tx_count"}, tx_wr_cnt, beats);
      chk({name, "_info_count"}, info_cnt, ok ? 1 : 0);
      if (ok) chk({name, "_info_word"}, last_info, info);
      chk({name, "_drop_cnt"}, drop_cnt, exp_drop);
      chk({name, "_state"}, ifm_in_fsm_dbg, 4'd0);
      chk({name, "_beats_left"}, exp_q.size(), 0);
   endtask

   task automatic run_vec(input int i);
      if (!tbl[i].ok) exp_drop++;
      tx_wr_cnt = 0;
      info_cnt  = 0;
      last_info = '0;
      push_frame(tbl[i].w0, tbl[i].w1, tbl[i].nctrl, tbl[i].nbeats,
                 tbl[i].kbody, tbl[i].klast, tbl[i].ok);
      wait_done(tbl[i].name);
      check_frame(tbl[i].name, tbl[i].ok ? tbl[i].nbeats : 0, tbl[i].ok, tbl[i].info);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int snap;
      tbl[0] = '{"good",      32'hA000_0000, 32'h0000_0001, 6, 8, 8'hFF, 8'h0F, 1'b1, 32'h0001_003C};
      tbl[1] = '{"bad_flag",  32'h5000_0000, 32'h0000_0000, 6, 3, 8'hFF, 8'hFF, 1'b0, 32'h0};
      tbl[2] = '{"short",     32'hA000_0000, 32'h0000_0001, 4, 2, 8'hFF, 8'h01, 1'b0, 32'h0};
      tbl[3] = '{"one_beat",  32'hA000_0000, 32'h0000_0000, 6, 1, 8'hFF, 8'h01, 1'b1, 32'h0000_0001};
      tbl[4] = '{"long",      32'hA000_0000, 32'h0000_0001, 7, 2, 8'hFF, 8'hFF, 1'b0, 32'h0};
      tbl[5] = '{"bad_keep",  32'hA123_4567, 32'h0000_0001, 6, 3, 8'hFF, 8'h05, 1'b1, 32'h0001_0010};
      tbl[6] = '{"csum_off",  32'hAFFF_FFFF, 32'hFFFF_FFFE, 6, 2, 8'h3F, 8'h7F, 1'b1, 32'h0000_000D};

      n_vec = 0; n_err = 0; exp_drop = 0; seed = 32'h1000_0001;
      tx_fifo_afull = 1'b0; tx_info_afull = 1'b0;
      c_force_empty = 1'b0; d_force_empty = 1'b0; bp_check = 1'b0;
      tx_wr_cnt = 0; info_cnt = 0; last_info = '0;
      refresh();
      mm2s_reset = 1'b1;
      repeat (3) tick();
      chk("rst_tx_wren", tx_fifo_wren, 0);
      chk("rst_tx_wdata", tx_fifo_wdata, 0);
      chk("rst_info_wren", tx_info_wren, 0);
      chk("rst_info_wdata", tx_info_wdata, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_dbg", ifm_in_fsm_dbg, 0);
      mm2s_reset = 1'b0;
      tick();

      for (int i = 0; i < 7; i++) run_vec(i);

      // Backpressure and data-FIFO underrun during an 8-beat frame.
      tx_wr_cnt = 0; info_cnt = 0; last_info = '0;
      bp_check = 1'b1;
      push_frame(32'hA000_0000, 32'h0000_0001, 6, 8, 8'hFF, 8'h0F, 1'b1);
      for (k = 0; k < 400; k++) begin
         if (cq.size() == 0 && dq.size() == 0 && ifm_in_fsm_dbg[2:0] == 3'd0) break;
         tx_fifo_afull = ((k / 2) % 2) == 1;
         d_force_empty = (k % 5) == 3;
         tick();
      end
      if (k == 400) flag_err("bp_timeout", ifm_in_fsm_dbg);
      tx_fifo_afull = 1'b0; d_force_empty = 1'b0; bp_check = 1'b0;
      repeat (3) tick();
      check_frame("bp", 8, 1'b1, 32'h0001_003C);

      // Info FIFO full holds the engine in idle.
      tx_wr_cnt = 0; info_cnt = 0; last_info = '0;
      tx_info_afull = 1'b1;
      push_frame(32'hA000_0000, 32'h0000_0000, 6, 2, 8'hFF, 8'hFF, 1'b1);
      repeat (6) tick();
      chk("iafull_state", ifm_in_fsm_dbg, 4'd0);
      chk("iafull_rden", ctrl_fifo_rden, 0);
      chk("iafull_ctrl_left", c_cnt, 6);
      tx_info_afull = 1'b0;
      wait_done("iafull");
      check_frame("iafull", 2, 1'b1, 32'h0000_0010);

      // Stall then reset in the middle of S_DATA.
      tx_wr_cnt = 0; info_cnt = 0; last_info = '0;
      push_frame(32'hA000_0000, 32'h0000_0001, 6, 4, 8'hFF, 8'hFF, 1'b1);
      for (k = 0; k < 50; k++) begin
         if (ifm_in_fsm_dbg[2:0] == 3'd2) break;
         tick();
      end
      if (k == 50) flag_err("rst_mid_reach_data", ifm_in_fsm_dbg);
      d_force_empty = 1'b1;
      tick();
      snap = tx_wr_cnt;
      repeat (4) tick();
      chk("stall_state", ifm_in_fsm_dbg, 4'd2);
      chk("stall_rden", data_fifo_rden, 0);
      chk("stall_tx_count", tx_wr_cnt, snap);
      chk("stall_beats_left", d_cnt, 4 - snap);
      mm2s_reset = 1'b1;
      tick();
      chk("rst_mid_tx_wren", tx_fifo_wren, 0);
      chk("rst_mid_tx_wdata", tx_fifo_wdata, 0);
      chk("rst_mid_info_wren", tx_info_wren, 0);
      chk("rst_mid_info_wdata", tx_info_wdata, 0);
      chk("rst_mid_drop_cnt", drop_cnt, 0);
      chk("rst_mid_dbg", ifm_in_fsm_dbg, 0);
      chk("rst_mid_rden", data_fifo_rden, 0);
      mm2s_reset = 1'b0;
      cq.delete(); dq.delete(); exp_q.delete();
      d_force_empty = 1'b0;
      refresh();
      exp_drop = 0;
      tick();
      run_vec(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ifm_in_fsm.md
Name: ifm_in_fsm

Overview:
- TX-direction (mm2s) framing engine for the 10GbE AXI Ethernet core; the counterpart of the RX output FSM.
- Consumes the 6-word AXI Ethernet TX application control stream and the matching 64-bit data stream from mm2s FIFOs.
- Writes frame data to the MAC-side TX data FIFO, then one per-frame info word (byte count, checksum enable).
- Frames with a malformed control block are discarded whole and counted.

Parameters:
C_CTRL_WORDS, 6, number of control words per frame (index 0..C_CTRL_WORDS-1)
C_TX_FLAG, 4'hA, required value of control word0 [31:28]

Ports:
mm2s_clk  in  1  clock
mm2s_reset  in  1  synchronous active-high reset
ctrl_fifo_rdata  in  37  [36]=last, [35:32]=keep, [31:0]=word; first-word-fall-through
ctrl_fifo_empty  in  1  control FIFO empty
ctrl_fifo_rden  out  1  pop control FIFO (combinational)
data_fifo_rdata  in  73  [72]=EOF, [71:64]=byte enables, [63:0]=data; FWFT
data_fifo_empty  in  1  data FIFO empty
data_fifo_rden  out  1  pop data FIFO (combinational)
tx_fifo_wdata  out  73  registered copy of popped data word
tx_fifo_wren  out  1  registered write strobe
tx_fifo_afull  in  1  TX data FIFO almost full (>=2 free entries when deasserted)
tx_info_wdata  out  32  [15:0]=byte count, [16]=csum_en, [31:17]=0
tx_info_wren  out  1  registered write strobe
tx_info_afull  in  1  TX info FIFO almost full
drop_cnt  out  16  frames dropped, saturating
ifm_in_fsm_dbg  out  4  [2:0]=state, [3]=tx_fifo_afull

Behaviour:
- Clock mm2s_clk. Reset mm2s_reset is synchronous, active-high.
- Reset, including mid-frame: state=S_IDLE; all strobes, wdata, counters and flags=0. FIFO contents are not flushed.
- States: S_IDLE=0, S_CTRL=1, S_DATA=2, S_DROP=3, S_INFO=4.
- S_IDLE: enter S_CTRL when !ctrl_fifo_empty && !tx_info_afull && !tx_fifo_afull. Clear widx, bytecnt, csum_en and bad.
- S_CTRL: ctrl_fifo_rden = !ctrl_fifo_empty. Each pop increments widx (3-bit, saturates at 7). Decoding per word index:
  - word0: bad |= ([31:28] != C_TX_FLAG).
  - word1: csum_en <= [0].
  - All other words are ignored.
- S_CTRL, last word: on a pop with [36]=1, bad |= (widx != C_CTRL_WORDS-1). Next state is S_DROP if bad (including this cycle's update), else S_DATA.
- S_CTRL, missing last: a word at index >= C_CTRL_WORDS without last sets bad; consumption continues until last.
- S_DATA: data_fifo_rden = !data_fifo_empty && !tx_fifo_afull.
  - Each pop drives tx_fifo_wdata<=rdata and tx_fifo_wren<=1 on the next cycle. Latency is 1 cycle; otherwise wren=0.
  - bytecnt += keep count (16-bit, saturates at 16'hFFFF).
  - Keep count: contiguous low enables 8'h01..8'hFF map to 1..8; any other pattern maps to 0.
  - A pop with [72]=1 goes to S_INFO.
- S_DROP: data_fifo_rden = !data_fifo_empty, with no TX writes. A pop with [72]=1 increments drop_cnt (saturating) and goes to S_IDLE.
- S_INFO: drives tx_info_wren<=1 and tx_info_wdata<={15'h0,csum_en,bytecnt} for exactly one cycle, then goes to S_IDLE.
  - The info write is always at least 1 cycle after the frame's last tx_fifo_wren.
- data_fifo_rden and ctrl_fifo_rden are never asserted in the same cycle, and never when the respective FIFO is empty.
- Empty data FIFO in S_DATA/S_DROP: stall with no pops and no writes. State and bytecnt are held.
- Minimum frame overhead: 1 (IDLE) + 6 (CTRL) + 1 (INFO) cycles beyond the data beats.

Decomposition:
- Shared package ifm_pkg holds:
  - state encodings S_*;
  - C_TX_FLAG;
  - bit-position constants for the last, keep and EOF fields;
  - the info-word field offsets, shared with the MAC-side reader.
- Optional sub-module ifm_keep_cnt: combinational 8-bit byte-enable to 4-bit count, reusable by the RX FSM.
- Everything else stays in one module.

Test Plan:
- Good frame: ctrl words A0000000,00000001,0,0,0,last-0 (6 words); 8 data beats with enables FF and final 0F+EOF -> 8 tx_fifo_wren beats with data unchanged; one info 0x0001003C (bytecnt 60, csum_en=1); drop_cnt=0.
- Bad flag: word0=50000000, 3 data beats -> no tx_fifo_wren, no tx_info_wren, all 3 beats popped, drop_cnt=1, FSM back in S_IDLE.
- Short control: last on word index 3 -> frame dropped, drop_cnt increments. Next well-formed frame transfers normally.
- Backpressure: tx_fifo_afull toggled every 2 cycles during an 8-beat frame; data_fifo_empty pulsed -> no pops while afull/empty; byte count correct; beat order preserved.
- tx_info_afull=1 with a control word pending -> stays in S_IDLE, ctrl_fifo_rden=0; release -> frame proceeds.
- Reset asserted mid-S_DATA -> next cycle all outputs 0, state S_IDLE, drop_cnt=0.
